// File: rtl/if_stage_pkg.sv
// ============================================================================
// if_stage_pkg : shared control encodings for next-PC selection
// Rev 1.0
// ============================================================================
`default_nettype none

package if_stage_pkg;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Any selection other than sequential fetch changes the control flow.
    function automatic logic npc_is_redirect(input logic [1:0] op);
        return (op != NPC_PLUS4);
    endfunction

endpackage

`default_nettype wire

// File: rtl/npc.sv
// ============================================================================
// npc : combinational next-PC target generator for redirects from decode
// Rev 1.0
// ============================================================================
`default_nettype none

module npc
    import if_stage_pkg::*;
(
    input  logic [31:0] ifid_pc4,
    input  logic [1:0]  NPCOp,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] jr_target,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] w_branch_off;

    assign w_branch_off = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        target = ifid_pc4;
        case (NPCOp)
            NPC_BRANCH: target = ifid_pc4 + w_branch_off;
            NPC_JUMP:   target = {ifid_pc4[31:28], imm26, 2'b00};
            NPC_JR:     target = jr_target;
            default:    target = ifid_pc4;
        endcase
    end

    assign misaligned = (target[1:0] != 2'b00);

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// if_stage : PC register, IF/ID pipeline register and fetch accounting
// Rev 1.0
// ============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic [1:0]  NPCOp,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] jr_target,
    output logic [31:0] im_addr,
    input  logic [31:0] im_dout,
    input  logic        im_ready,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [5:0]  Op,
    output logic [5:0]  Funct,
    output logic        pc_err,
    output logic [31:0] fetch_cnt
);

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q,   pc4_d;
    logic        valid_q, valid_d;
    logic        err_q,   err_d;
    logic [31:0] cnt_q,   cnt_d;

    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_redirect;
    logic [31:0] w_pc_plus4;

    npc u_npc (
        .ifid_pc4   (pc4_q),
        .NPCOp      (NPCOp),
        .imm16      (imm16),
        .imm26      (imm26),
        .jr_target  (jr_target),
        .target     (w_target),
        .misaligned (w_misaligned)
    );

    // A bubble in IF/ID carries no decoded control, so it can never redirect.
    assign w_redirect = valid_q && !stall && npc_is_redirect(NPCOp);
    assign w_pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (stall) begin
            // everything holds
        end else if (w_redirect) begin
            pc_d    = {w_target[31:2], 2'b00};
            valid_d = 1'b0;
            if (w_misaligned) begin
                err_d = 1'b1;
            end
        end else if (im_ready) begin
            instr_d = im_dout;
            pc4_d   = w_pc_plus4;
            valid_d = 1'b1;
            pc_d    = w_pc_plus4;
            cnt_d   = cnt_q + 32'd1;
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 32'h0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign im_addr    = pc_q;
    assign ifid_instr = instr_q;
    assign ifid_pc4   = pc4_q;
    assign ifid_valid = valid_q;
    assign Op         = instr_q[31:26];
    assign Funct      = instr_q[5:0];
    assign pc_err     = err_q;
    assign fetch_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage : directed self-checking bench for if_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic [1:0]  NPCOp;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] jr_target;
    logic [31:0] im_addr;
    logic [31:0] im_dout;
    logic        im_ready;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        pc_err;
    logic [31:0] fetch_cnt;

    int total = 0;
    int bad   = 0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .stall      (stall),
        .NPCOp      (NPCOp),
        .imm16      (imm16),
        .imm26      (imm26),
        .jr_target  (jr_target),
        .im_addr    (im_addr),
        .im_dout    (im_dout),
        .im_ready   (im_ready),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid),
        .Op         (Op),
        .Funct      (Funct),
        .pc_err     (pc_err),
        .fetch_cnt  (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: address 0 holds addi, everything else tags its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return {16'hAB00, a[15:0]};
    endfunction

    always_comb im_dout = mem_word(im_addr);

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; stall = 1'b0; NPCOp = 2'b00; imm16 = '0; imm26 = '0;
        jr_target = '0; im_ready = 1'b0;
        #2;
        total++; if (im_addr !== 32'h0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0) begin
            bad++; $display("FAIL reset_regs pc=%h instr=%h pc4=%h want 0", im_addr, ifid_instr, ifid_pc4);
        end
        total++; if (ifid_valid !== 1'b0 || pc_err !== 1'b0 || fetch_cnt !== 32'h0) begin
            bad++; $display("FAIL reset_flags valid=%b err=%b cnt=%0d want 0", ifid_valid, pc_err, fetch_cnt);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_first_fetch();
        im_ready = 1'b1;
        step();
        total++; if (ifid_instr !== 32'h2008_0005 || ifid_pc4 !== 32'h4 || im_addr !== 32'h4) begin
            bad++; $display("FAIL first_fetch instr=%h pc4=%h pc=%h want 20080005/4/4", ifid_instr, ifid_pc4, im_addr);
        end
        total++; if (fetch_cnt !== 32'd1 || Op !== 6'h08 || Funct !== 6'h05 || ifid_valid !== 1'b1) begin
            bad++; $display("FAIL first_fields cnt=%0d op=%h funct=%h valid=%b want 1/08/05/1", fetch_cnt, Op, Funct, ifid_valid);
        end
    endtask

    task automatic test_bubble_no_redirect();
        im_ready = 1'b0;
        step();
        NPCOp = 2'b10; imm26 = 26'h3FF_FFFF; im_ready = 1'b1;
        step();
        total++; if (im_addr !== 32'h8 || ifid_pc4 !== 32'h8 || ifid_instr !== 32'hAB00_0004 || fetch_cnt !== 32'd2) begin
            bad++; $display("FAIL bubble_no_redirect pc=%h pc4=%h instr=%h cnt=%0d want 8/8/AB000004/2", im_addr, ifid_pc4, ifid_instr, fetch_cnt);
        end
        NPCOp = 2'b00;
    endtask

    task automatic test_branch();
        step(); step();
        total++; if (ifid_pc4 !== 32'h10 || fetch_cnt !== 32'd4) begin
            bad++; $display("FAIL branch_setup pc4=%h cnt=%0d want 10/4", ifid_pc4, fetch_cnt);
        end
        NPCOp = 2'b01; imm16 = 16'hFFFE;
        step();
        total++; if (im_addr !== 32'h8 || ifid_valid !== 1'b0 || fetch_cnt !== 32'd4) begin
            bad++; $display("FAIL branch_taken pc=%h valid=%b cnt=%0d want 8/0/4", im_addr, ifid_valid, fetch_cnt);
        end
        NPCOp = 2'b00;
        step();
        total++; if (ifid_instr !== 32'hAB00_0008 || ifid_pc4 !== 32'hC || im_addr !== 32'hC || fetch_cnt !== 32'd5) begin
            bad++; $display("FAIL branch_refetch instr=%h pc4=%h pc=%h cnt=%0d want AB000008/C/C/5", ifid_instr, ifid_pc4, im_addr, fetch_cnt);
        end
    endtask

    task automatic test_jump_jr();
        NPCOp = 2'b11; jr_target = 32'hA000_0000;
        step();
        NPCOp = 2'b00;
        step();
        total++; if (ifid_pc4 !== 32'hA000_0004 || fetch_cnt !== 32'd6 || ifid_valid !== 1'b1) begin
            bad++; $display("FAIL jr_fetch pc4=%h cnt=%0d valid=%b want A0000004/6/1", ifid_pc4, fetch_cnt, ifid_valid);
        end
        NPCOp = 2'b10; imm26 = 26'h000_0040;
        step();
        total++; if (im_addr !== 32'hA000_0100 || ifid_valid !== 1'b0 || pc_err !== 1'b0) begin
            bad++; $display("FAIL jump pc=%h valid=%b err=%b want A0000100/0/0", im_addr, ifid_valid, pc_err);
        end
        NPCOp = 2'b00;
        step();
        NPCOp = 2'b11; jr_target = 32'h0000_0102;
        step();
        total++; if (im_addr !== 32'h100 || pc_err !== 1'b1 || fetch_cnt !== 32'd7) begin
            bad++; $display("FAIL jr_misaligned pc=%h err=%b cnt=%0d want 100/1/7", im_addr, pc_err, fetch_cnt);
        end
        NPCOp = 2'b00;
    endtask

    task automatic test_stall();
        step();
        total++; if (ifid_instr !== 32'hAB00_0100 || im_addr !== 32'h104 || fetch_cnt !== 32'd8) begin
            bad++; $display("FAIL stall_setup instr=%h pc=%h cnt=%0d want AB000100/104/8", ifid_instr, im_addr, fetch_cnt);
        end
        stall = 1'b1; NPCOp = 2'b10; imm26 = 26'h000_0123;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (im_addr !== 32'h104 || ifid_instr !== 32'hAB00_0100 || ifid_pc4 !== 32'h104 ||
                         ifid_valid !== 1'b1 || fetch_cnt !== 32'd8) begin
                bad++; $display("FAIL stall_hold cyc=%0d pc=%h instr=%h pc4=%h valid=%b cnt=%0d want 104/AB000100/104/1/8",
                                i, im_addr, ifid_instr, ifid_pc4, ifid_valid, fetch_cnt);
            end
        end
        stall = 1'b0;
        step();
        total++; if (im_addr !== 32'h48C || ifid_valid !== 1'b0 || fetch_cnt !== 32'd8) begin
            bad++; $display("FAIL stall_release pc=%h valid=%b cnt=%0d want 48C/0/8", im_addr, ifid_valid, fetch_cnt);
        end
        NPCOp = 2'b00;
    endtask

    task automatic test_ready_low();
        step();
        im_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (im_addr !== 32'h490 || ifid_valid !== 1'b0 || fetch_cnt !== 32'd9 ||
                         ifid_instr !== 32'hAB00_048C || ifid_pc4 !== 32'h490) begin
                bad++; $display("FAIL ready_low cyc=%0d pc=%h valid=%b cnt=%0d instr=%h pc4=%h want 490/0/9/AB00048C/490",
                                i, im_addr, ifid_valid, fetch_cnt, ifid_instr, ifid_pc4);
            end
        end
        im_ready = 1'b1;
        step();
        total++; if (ifid_instr !== 32'hAB00_0490 || im_addr !== 32'h494 || fetch_cnt !== 32'd10 || ifid_valid !== 1'b1) begin
            bad++; $display("FAIL ready_resume instr=%h pc=%h cnt=%0d valid=%b want AB000490/494/10/1", ifid_instr, im_addr, fetch_cnt, ifid_valid);
        end
    endtask

    task automatic test_wrap();
        NPCOp = 2'b11; jr_target = 32'hFFFF_FFFC;
        step();
        NPCOp = 2'b00;
        total++; if (im_addr !== 32'hFFFF_FFFC || pc_err !== 1'b1) begin
            bad++; $display("FAIL wrap_setup pc=%h err=%b want FFFFFFFC/1", im_addr, pc_err);
        end
        step();
        total++; if (im_addr !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_instr !== 32'hAB00_FFFC || fetch_cnt !== 32'd11) begin
            bad++; $display("FAIL wrap pc=%h pc4=%h instr=%h cnt=%0d want 0/0/AB00FFFC/11", im_addr, ifid_pc4, ifid_instr, fetch_cnt);
        end
    endtask

    task automatic test_async_reset();
        NPCOp = 2'b11; jr_target = 32'h0000_0040;
        step();
        total++; if (im_addr !== 32'h40) begin
            bad++; $display("FAIL areset_setup pc=%h want 40", im_addr);
        end
        stall = 1'b1; NPCOp = 2'b10;
        #2 rstn = 1'b0;
        #1;
        total++; if (im_addr !== 32'h0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0 ||
                     ifid_valid !== 1'b0 || pc_err !== 1'b0 || fetch_cnt !== 32'h0) begin
            bad++; $display("FAIL async_reset pc=%h instr=%h pc4=%h valid=%b err=%b cnt=%0d want all 0",
                            im_addr, ifid_instr, ifid_pc4, ifid_valid, pc_err, fetch_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        stall = 1'b0; NPCOp = 2'b00; rstn = 1'b1;
        step();
        total++; if (ifid_instr !== 32'h2008_0005 || im_addr !== 32'h4 || fetch_cnt !== 32'd1 || ifid_valid !== 1'b1) begin
            bad++; $display("FAIL post_reset instr=%h pc=%h cnt=%0d valid=%b want 20080005/4/1/1", ifid_instr, im_addr, fetch_cnt, ifid_valid);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_bubble_no_redirect();
        test_branch();
        test_jump_jr();
        test_stall();
        test_ready_low();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
